// File: rtl/cram_arbiter.sv
// Round-robin two-port arbiter that sequences cRAM accesses as SETUP/EXEC/DONE.
// Optional address-range check and err output enabled by `define CRAM_ADDR_CHECK_EN.
module cram_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_rw,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_ack,
  output logic [DWIDTH-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_rw,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  output logic              b_ack,
  output logic [DWIDTH-1:0] b_rdata,
  output logic              mem_rw,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy
`ifdef CRAM_ADDR_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, EXEC, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                last_b;
  logic                gnt_b;
  logic                lat_rw;
  logic                any_req;
  logic                pick_b;
  logic [AWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   rd_capture;
`ifdef CRAM_ADDR_CHECK_EN
  localparam logic [AWIDTH:0] DEPTH_LIM = (AWIDTH + 1)'(DEPTH);
  logic                oor;
`endif

  if (DEPTH < 1 || DEPTH > (1 << AWIDTH)) begin : g_depth_chk
    $error("cram_arbiter: DEPTH must lie in 1..2**AWIDTH");
  end

  assign any_req  = a_req | b_req;
  // A loses a tie only when it was the previous winner.
  assign pick_b   = b_req & (~a_req | ~last_b);
  assign sel_addr = pick_b ? b_addr : a_addr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rw = 1'b1;
    a_ack  = 1'b0;
    b_ack  = 1'b0;
    busy   = (state != IDLE);
`ifdef CRAM_ADDR_CHECK_EN
    err    = 1'b0;
`endif
    case (state)
      EXEC: begin
`ifdef CRAM_ADDR_CHECK_EN
        mem_rw = lat_rw | oor;
`else
        mem_rw = lat_rw;
`endif
      end
      DONE: begin
        a_ack = ~gnt_b;
        b_ack = gnt_b;
`ifdef CRAM_ADDR_CHECK_EN
        err   = oor;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
`ifdef CRAM_ADDR_CHECK_EN
    rd_capture = oor ? '0 : mem_rdata;
`else
    rd_capture = mem_rdata;
`endif
  end

  // mem_addr/mem_wdata double as the latched request, so they only move at grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b    <= 1'b1;
      gnt_b     <= 1'b0;
      lat_rw    <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
`ifdef CRAM_ADDR_CHECK_EN
      oor       <= 1'b0;
`endif
    end else begin
      if (state == IDLE && any_req) begin
        gnt_b     <= pick_b;
        last_b    <= pick_b;
        lat_rw    <= pick_b ? b_rw : a_rw;
        mem_addr  <= sel_addr;
        mem_wdata <= pick_b ? b_wdata : a_wdata;
`ifdef CRAM_ADDR_CHECK_EN
        oor       <= ({1'b0, sel_addr} >= DEPTH_LIM);
`endif
      end
      if (state == EXEC && lat_rw) begin
        if (gnt_b) b_rdata <= rd_capture;
        else       a_rdata <= rd_capture;
      end
    end
  end

endmodule
